// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// It also holds a width helper that the round-robin picker and the top both use.
package regfile_wport_arbiter_pkg;

  localparam int unsigned RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] u5;
  typedef logic [63:0]          u64;

  typedef struct packed {
    logic valid;
    u5    wd;
    u64   data;
  } RF_WRITE_REQ;

  // Index width for n requesters; never zero so single-requester builds stay legal.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wport_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
// It outputs a one-hot grant, the binary index of the winner and an any-request flag.
module regfile_wport_arbiter_rr_picker
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]             req,
  input  logic [idxWidth(N)-1:0]   ptr,
  output logic [N-1:0]             grant,
  output logic [idxWidth(N)-1:0]   idx,
  output logic                     any
);

  localparam int unsigned IDX_W = idxWidth(N);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = IDX_W'((32'(ptr) + off) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the integer register-file write port between writeback (default priority) and
// N_REQ long-latency units, with round-robin among units and a starvation-driven stall.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_wb_en,
  input  logic [RF_ADDR_W-1:0]         pipe_wd,
  input  logic [XLEN-1:0]              pipe_wdata,
  output logic                         pipe_stall,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*RF_ADDR_W-1:0]   req_wd,
  input  logic [N_REQ*XLEN-1:0]        req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         rf_we,
  output logic [RF_ADDR_W-1:0]         rf_wd,
  output logic [XLEN-1:0]              rf_wdata,
  output logic [$clog2(N_REQ+1)-1:0]   rf_src
);

  localparam int unsigned SRC_W = $clog2(N_REQ + 1);
  localparam int unsigned IDX_W = idxWidth(N_REQ);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [IDX_W-1:0]     rrPtr, rrPtrNext;
  logic [CNT_W-1:0]     starveCnt, starveCntNext;
  logic                 stallNext;

  logic [N_REQ-1:0]     pickGrant;
  logic [IDX_W-1:0]     pickIdx;
  logic                 pickAny;

  logic                 pipeWins, unitWins, winValid;
  logic [RF_ADDR_W-1:0] winWd;
  logic [XLEN-1:0]      winData;
  logic [SRC_W-1:0]     winSrc;

  regfile_wport_arbiter_rr_picker #(
    .N (N_REQ)
  ) uPicker (
    .req   (req_valid),
    .ptr   (rrPtr),
    .grant (pickGrant),
    .idx   (pickIdx),
    .any   (pickAny)
  );

  always_comb begin
    pipeWins  = pipe_wb_en & ~pipe_stall;
    unitWins  = ~pipeWins & pickAny & ~rst;
    req_ready = unitWins ? pickGrant : '0;
    winValid  = pipeWins | unitWins;

    winWd   = pipe_wd;
    winData = pipe_wdata;
    winSrc  = '0;
    if (unitWins) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (pickGrant[i]) begin
          winWd   = req_wd[i*RF_ADDR_W +: RF_ADDR_W];
          winData = req_data[i*XLEN +: XLEN];
          winSrc  = SRC_W'(i + 1);
        end
      end
    end

    rrPtrNext = rrPtr;
    if (unitWins) begin
      rrPtrNext = (pickIdx == IDX_W'(N_REQ - 1)) ? '0 : pickIdx + IDX_W'(1);
    end

    // Counts cycles a unit waits behind the pipeline; a grant or an idle unit side clears it.
    starveCntNext = starveCnt;
    if (unitWins || !(|req_valid)) begin
      starveCntNext = '0;
    end else if (pipeWins && (starveCnt != CNT_W'(STARVE_LIMIT))) begin
      starveCntNext = starveCnt + CNT_W'(1);
    end
    stallNext = (starveCntNext == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_wd      <= '0;
      rf_wdata   <= '0;
      rf_src     <= '0;
      pipe_stall <= 1'b0;
      rrPtr      <= '0;
      starveCnt  <= '0;
    end else begin
      rf_we      <= winValid && (winWd != '0);
      pipe_stall <= stallNext;
      rrPtr      <= rrPtrNext;
      starveCnt  <= starveCntNext;
      if (winValid) begin
        rf_wd    <= winWd;
        rf_wdata <= winData;
        rf_src   <= winSrc;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (rst) !(pipeWins && (|req_ready)));

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: expected register-file writes are queued by the
// stimulus and checked by an independent monitor; handshake outputs are checked inline.
module tb_regfile_wport_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         pipe_wb_en;
  logic [4:0]   pipe_wd;
  logic [63:0]  pipe_wdata;
  logic         pipe_stall;
  logic [1:0]   req_valid;
  logic [9:0]   req_wd;
  logic [127:0] req_data;
  logic [1:0]   req_ready;
  logic         rf_we;
  logic [4:0]   rf_wd;
  logic [63:0]  rf_wdata;
  logic [1:0]   rf_src;

  typedef struct {
    int          cyc;
    logic [4:0]  wd;
    logic [63:0] data;
    logic [1:0]  src;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cycNow = 0;

  regfile_wport_arbiter #(
    .N_REQ        (2),
    .XLEN         (64),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_wb_en (pipe_wb_en),
    .pipe_wd    (pipe_wd),
    .pipe_wdata (pipe_wdata),
    .pipe_stall (pipe_stall),
    .req_valid  (req_valid),
    .req_wd     (req_wd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rf_we      (rf_we),
    .rf_wd      (rf_wd),
    .rf_wdata   (rf_wdata),
    .rf_src     (rf_src)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycNow <= cycNow + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (expQ.size() > 0 && expQ[0].cyc < cycNow) begin
        checks++;
        errors++;
        $display("FAIL missing_write cycle=%0d expected wd=%0d data=%0h src=%0d",
                 expQ[0].cyc, expQ[0].wd, expQ[0].data, expQ[0].src);
        void'(expQ.pop_front());
      end
      if (rf_we) begin
        checks++;
        if (expQ.size() == 0 || expQ[0].cyc != cycNow) begin
          errors++;
          $display("FAIL unexpected_write cycle=%0d actual wd=%0d data=%0h src=%0d",
                   cycNow, rf_wd, rf_wdata, rf_src);
        end else begin
          expT e;
          e = expQ.pop_front();
          if (rf_wd !== e.wd || rf_wdata !== e.data || rf_src !== e.src) begin
            errors++;
            $display("FAIL write_content cycle=%0d actual wd=%0d data=%0h src=%0d expected wd=%0d data=%0h src=%0d",
                     cycNow, rf_wd, rf_wdata, rf_src, e.wd, e.data, e.src);
          end
        end
      end
    end
  end

  // One cycle: drive inputs, check combinational handshake, queue the expected write.
  task automatic step(input string nm, input logic pe, input logic [4:0] pwd,
                      input logic [63:0] pd, input logic [1:0] v, input logic [1:0] expRdy,
                      input logic expStall, input logic expWe, input logic [4:0] ewd,
                      input logic [63:0] ed, input logic [1:0] esrc);
    expT e;
    pipe_wb_en = pe;
    pipe_wd    = pwd;
    pipe_wdata = pd;
    req_valid  = v;
    @(negedge clk);
    chk({nm, "_ready"}, 64'(req_ready), 64'(expRdy));
    chk({nm, "_stall"}, 64'(pipe_stall), 64'(expStall));
    if (expWe) begin
      e.cyc  = cycNow + 1;
      e.wd   = ewd;
      e.data = ed;
      e.src  = esrc;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    pipe_wb_en = 1'b0;
    pipe_wd    = '0;
    pipe_wdata = '0;
    req_valid  = '0;
    req_wd     = {5'd7, 5'd3};
    req_data   = {64'hB1, 64'hA0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_stall", 64'(pipe_stall), 64'd0);
    rst = 1'b0;

    // Pipeline-only write.
    step("pipe_only", 1'b1, 5'd5, 64'hDEAD, 2'b00, 2'b00, 1'b0, 1'b1, 5'd5, 64'hDEAD, 2'd0);

    // Reset mid-stream with both units valid: the pending grant is dropped.
    pipe_wb_en = 1'b0;
    req_valid  = 2'b11;
    @(negedge clk);
    chk("pre_rst_ready", 64'(req_ready), 64'(2'b01));
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_wd", 64'(rf_wd), 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_rf_src", 64'(rf_src), 64'd0);
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_edge_ready", 64'(req_ready), 64'd0);
    chk("rst_edge_rf_we", 64'(rf_we), 64'd0);
    rst = 1'b0;

    // Round robin with both units held valid.
    step("rr0", 1'b0, 5'd0, 64'h0, 2'b11, 2'b01, 1'b0, 1'b1, 5'd3, 64'hA0, 2'd1);
    step("rr1", 1'b0, 5'd0, 64'h0, 2'b11, 2'b10, 1'b0, 1'b1, 5'd7, 64'hB1, 2'd2);
    step("rr2", 1'b0, 5'd0, 64'h0, 2'b11, 2'b01, 1'b0, 1'b1, 5'd3, 64'hA0, 2'd1);
    step("rr3", 1'b0, 5'd0, 64'h0, 2'b11, 2'b10, 1'b0, 1'b1, 5'd7, 64'hB1, 2'd2);

    // Starvation: pipeline owns the port four cycles, then is stalled for one.
    for (int i = 0; i < 4; i++) begin
      step("starve_pipe", 1'b1, 5'd9, 64'h99, 2'b01, 2'b00, 1'b0, 1'b1, 5'd9, 64'h99, 2'd0);
    end
    step("starve_stall", 1'b1, 5'd9, 64'h99, 2'b01, 2'b01, 1'b1, 1'b1, 5'd3, 64'hA0, 2'd1);
    step("starve_after", 1'b1, 5'd9, 64'h99, 2'b00, 2'b00, 1'b0, 1'b1, 5'd9, 64'h99, 2'd0);

    // x0 destination: handshake completes, no regfile write, pointer wraps to 0.
    req_wd   = {5'd0, 5'd3};
    req_data = {64'h1234, 64'hA0};
    step("x0_grant", 1'b0, 5'd0, 64'h0, 2'b10, 2'b10, 1'b0, 1'b0, 5'd0, 64'h0, 2'd0);
    chk("x0_no_we", 64'(rf_we), 64'd0);
    step("x0_wrap", 1'b0, 5'd0, 64'h0, 2'b11, 2'b01, 1'b0, 1'b1, 5'd3, 64'hA0, 2'd1);
    step("idle", 1'b0, 5'd0, 64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 64'h0, 2'd0);
    chk("idle_no_we", 64'(rf_we), 64'd0);
    chk("idle_hold_wd", 64'(rf_wd), 64'd3);
    chk("idle_hold_data", rf_wdata, 64'hA0);

    // Simultaneous request: pipeline first, unit next; counter must restart from zero.
    step("sim_pipe", 1'b1, 5'd12, 64'hC0DE, 2'b01, 2'b00, 1'b0, 1'b1, 5'd12, 64'hC0DE, 2'd0);
    step("sim_unit", 1'b0, 5'd0, 64'h0, 2'b01, 2'b01, 1'b0, 1'b1, 5'd3, 64'hA0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      step("sim_nostall", 1'b1, 5'd12, 64'hC0DE, 2'b01, 2'b00, 1'b0, 1'b1, 5'd12, 64'hC0DE,
           2'd0);
    end
    step("sim_stall", 1'b1, 5'd12, 64'hC0DE, 2'b01, 2'b01, 1'b1, 1'b1, 5'd3, 64'hA0, 2'd1);
    step("sim_after", 1'b1, 5'd12, 64'hC0DE, 2'b00, 2'b00, 1'b0, 1'b1, 5'd12, 64'hC0DE, 2'd0);
    step("drain0", 1'b0, 5'd0, 64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 64'h0, 2'd0);
    step("drain1", 1'b0, 5'd0, 64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 64'h0, 2'd0);

    chk("queue_drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
